// File: rtl/ibex_hpm_event_ctrl.sv
// Event routing, CSR write decode and overflow tracking for a bank of hpm counters.
// Sits in front of the ibex_counter instances and drives their inc/we/wdata inputs.
module ibex_hpm_event_ctrl #(
  parameter int unsigned NumCounters  = 8,
  parameter int unsigned NumEvents    = 16,
  parameter int unsigned CounterWidth = 40,
  localparam int unsigned SelW        = (NumCounters > 1) ? $clog2(NumCounters) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumEvents-1:0]      event_i,
  input  logic                      csr_we_i,
  input  logic [SelW-1:0]           csr_sel_i,
  input  logic [1:0]                csr_kind_i,
  input  logic [31:0]               csr_wdata_i,
  output logic [31:0]               csr_rdata_o,
  input  logic [NumCounters*64-1:0] cnt_val_i,
  output logic [NumCounters-1:0]    cnt_inc_o,
  output logic [NumCounters-1:0]    cnt_we_o,
  output logic [NumCounters-1:0]    cnth_we_o,
  output logic [31:0]               cnt_wdata_o,
  output logic                      irq_ovf_o
);

  localparam logic [1:0] KindCntLo = 2'b00;
  localparam logic [1:0] KindCntHi = 2'b01;
  localparam logic [1:0] KindEvent = 2'b10;
  localparam logic [1:0] KindInhib = 2'b11;

  logic [NumEvents-1:0]        event_q;
  logic [NumCounters-1:0][4:0] sel_q, sel_d;
  logic [NumCounters-1:0]      ie_q, ie_d;
  logic [NumCounters-1:0]      of_q, of_d;
  logic [NumCounters-1:0]      inhibit_q, inhibit_d;

  logic                        sel_valid;
  logic [NumCounters-1:0]      ev_we;
  logic                        inh_we;
  logic [NumCounters-1:0]      ev_hit;
  logic [NumCounters-1:0]      ovf_set;

  assign sel_valid   = (32'(csr_sel_i) < NumCounters);
  assign cnt_wdata_o = csr_wdata_i;
  assign irq_ovf_o   = |(of_q & ie_q);

  // Strobes are gated by reset so they drop as soon as reset asserts.
  always_comb begin
    cnt_we_o  = '0;
    cnth_we_o = '0;
    ev_we     = '0;
    inh_we    = 1'b0;
    if (csr_we_i && rst_ni) begin
      if (csr_kind_i == KindInhib) begin
        inh_we = 1'b1;
      end else if (sel_valid) begin
        for (int i = 0; i < NumCounters; i++) begin
          if (csr_sel_i == SelW'(i)) begin
            cnt_we_o[i]  = (csr_kind_i == KindCntLo);
            cnth_we_o[i] = (csr_kind_i == KindCntHi);
            ev_we[i]     = (csr_kind_i == KindEvent);
          end
        end
      end
    end
  end

  always_comb begin
    ev_hit = '0;
    for (int i = 0; i < NumCounters; i++) begin
      for (int k = 1; k <= NumEvents; k++) begin
        if (sel_q[i] == 5'(k)) begin
          ev_hit[i] = event_q[k-1];
        end
      end
    end
  end

  // A software write to the same counter takes priority over counting.
  always_comb begin
    cnt_inc_o = '0;
    ovf_set   = '0;
    for (int i = 0; i < NumCounters; i++) begin
      cnt_inc_o[i] = ev_hit[i] & ~inhibit_q[i] & ~cnt_we_o[i] & ~cnth_we_o[i];
      ovf_set[i]   = cnt_inc_o[i] &
                     (cnt_val_i[64*i +: CounterWidth] == {CounterWidth{1'b1}});
    end
  end

  // Hardware overflow set overrides a concurrent software clear of the flag.
  always_comb begin
    sel_d     = sel_q;
    ie_d      = ie_q;
    of_d      = of_q;
    inhibit_d = inh_we ? csr_wdata_i[NumCounters-1:0] : inhibit_q;
    for (int i = 0; i < NumCounters; i++) begin
      if (ev_we[i]) begin
        sel_d[i] = csr_wdata_i[4:0];
        ie_d[i]  = csr_wdata_i[30];
        of_d[i]  = csr_wdata_i[31];
      end
      of_d[i] = of_d[i] | ovf_set[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      event_q   <= '0;
      sel_q     <= '0;
      ie_q      <= '0;
      of_q      <= '0;
      inhibit_q <= '0;
    end else begin
      event_q   <= event_i;
      sel_q     <= sel_d;
      ie_q      <= ie_d;
      of_q      <= of_d;
      inhibit_q <= inhibit_d;
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    if (csr_kind_i == KindInhib) begin
      csr_rdata_o = 32'(inhibit_q);
    end else if (sel_valid) begin
      for (int i = 0; i < NumCounters; i++) begin
        if (csr_sel_i == SelW'(i)) begin
          case (csr_kind_i)
            KindCntLo: csr_rdata_o = cnt_val_i[64*i +: 32];
            KindCntHi: csr_rdata_o = cnt_val_i[64*i+32 +: 32];
            KindEvent: csr_rdata_o = {of_q[i], ie_q[i], 25'b0, sel_q[i]};
            default:   csr_rdata_o = '0;
          endcase
        end
      end
    end
  end

endmodule
